tlb_assoc: RTL
==============

Name: tlb_assoc

Overview:
- Parametrised, fully-associative, thread-tagged TLB. It is the generalised successor of the fixed single-thread vpn_t→ppn_t mapping.
- One instance serves as the ITLB and a second as the DTLB. Lookup is pipelined with 1-cycle latency.
- Entries are filled by the tlbwrite instruction (tlbwrite_t itlb/dtlb selects the instance) and invalidated by per-thread or global flush.
- A miss response drives the itlb_miss/dtlb_miss exception path.

Parameters:
- N_ENTRIES, 4, number of TLB entries; power of 2, range 2..32.
- VPN_W, 20, virtual page number width.
- PPN_W, 8, physical page number width.
- OFF_W, 12, page offset width.
- TID_W, 3, thread id width (matches threadid_t).
- CNT_W, 16, miss counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request this cycle.
- req_tid  in  TID_W  requesting thread.
- req_vaddr  in  VPN_W+OFF_W  virtual address.
- rsp_valid  out  1  lookup result valid (1 cycle after req_valid).
- rsp_hit  out  1  translation found.
- rsp_miss  out  1  translation not found (exception request); equals rsp_valid & ~rsp_hit.
- rsp_paddr  out  PPN_W+OFF_W  {ppn, offset}; zero on miss.
- rsp_tid  out  TID_W  thread of the response.
- wr_en  in  1  install/update entry.
- wr_tid  in  TID_W  owning thread.
- wr_vpn  in  VPN_W  virtual page.
- wr_ppn  in  PPN_W  physical page.
- flush_all  in  1  invalidate all entries.
- flush_tid_en  in  1  invalidate entries of flush_tid.
- flush_tid  in  TID_W  thread to flush.
- n_valid  out  $clog2(N_ENTRIES)+1  count of valid entries.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async, rst_n=0):
  - All valid bits are cleared and the victim pointer is 0.
  - Outputs are all 0: rsp_valid, rsp_hit, rsp_miss, rsp_paddr, rsp_tid, n_valid, miss_count.
  - Reset asserted mid-lookup drops the in-flight response; no rsp_valid pulse follows deassertion.
- Entry state: valid, tid, vpn, ppn.
- Lookup:
  - Cycle N: req_valid is sampled and all entries are compared in parallel. Match = valid & tid==req_tid & vpn==req_vaddr[VPN_W+OFF_W-1:OFF_W].
  - Cycle N+1: rsp_* are registered outputs. A request every cycle is accepted (full throughput, no stall).
  - rsp_paddr = {matched ppn, req offset} on hit; 0 on miss.
  - If req_valid=0, rsp_valid=0 next cycle; rsp_hit, rsp_miss and rsp_paddr also read 0.
- Multiple matches cannot occur: write-update guarantees uniqueness per (tid, vpn).
- Lookup/update ordering: lookup uses the array state at the start of cycle N. A write or flush in the same cycle is not visible until cycle N+1's request.
- Write (wr_en, no flush this cycle):
  - If (wr_tid, wr_vpn) already present: update ppn in place. Victim pointer and n_valid are unchanged.
  - Else if any invalid entry: fill the lowest-index invalid entry; n_valid increments.
  - Else: replace the entry at the victim pointer, then victim pointer = (ptr+1) mod N_ENTRIES (round-robin). n_valid stays N_ENTRIES.
- Flush:
  - flush_all clears all valid bits.
  - flush_tid_en clears the valid bits of entries whose tid==flush_tid.
  - Victim pointer is not changed by either flush.
  - Any flush in a cycle drops a concurrent wr_en; the write is lost, not deferred.
  - flush_all and flush_tid_en together behave as flush_all.
- miss_count:
  - Increments in the cycle rsp_miss is driven.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- n_valid reflects the array after the current cycle's write/flush, registered.

Test Plan:
- Reset, then lookup tid 0 vaddr 0x00001234 → next cycle rsp_valid=1, rsp_miss=1, rsp_paddr=0, miss_count=1.
- Write tid 2, vpn 0x00001, ppn 0x3A; lookup tid 2 vaddr 0x00001ABC → rsp_hit=1, rsp_paddr=0x3AABC. The same lookup with tid 3 → miss.
- Fill 4 entries (vpn 1..4, tid 0), then write vpn 5 → entry 0 replaced. Lookup vpn 1 misses, vpn 5 hits. Write vpn 6 → entry 1 replaced. n_valid stays 4.
- Rewrite (tid 0, vpn 2) with ppn 0x77 while full → in-place update: lookup vpn 2 gives ppn 0x77, vpn 3 and 4 still hit, victim pointer unchanged.
- Write and lookup of the same new vpn in the same cycle → that lookup misses. The following cycle's lookup hits.
- Entries for tid 1 and tid 4, then flush_tid_en with tid 1 plus wr_en in the same cycle → tid 1 entries miss, tid 4 hits, the write is absent. Then flush_all → n_valid=0. Assert rst_n low with req_valid high → no rsp_valid after release.

Source files
------------

// File: rtl/tlb_assoc.sv
// Fully-associative, thread-tagged TLB with 1-cycle registered lookup,
// in-place update, lowest-free fill, round-robin replacement and per-thread/global flush.
module tlb_assoc #(
  parameter int N_ENTRIES = 4,
  parameter int VPN_W     = 20,
  parameter int PPN_W     = 8,
  parameter int OFF_W     = 12,
  parameter int TID_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [TID_W-1:0]             req_tid,
  input  logic [VPN_W+OFF_W-1:0]       req_vaddr,
  output logic                         rsp_valid,
  output logic                         rsp_hit,
  output logic                         rsp_miss,
  output logic [PPN_W+OFF_W-1:0]       rsp_paddr,
  output logic [TID_W-1:0]             rsp_tid,
  input  logic                         wr_en,
  input  logic [TID_W-1:0]             wr_tid,
  input  logic [VPN_W-1:0]             wr_vpn,
  input  logic [PPN_W-1:0]             wr_ppn,
  input  logic                         flush_all,
  input  logic                         flush_tid_en,
  input  logic [TID_W-1:0]             flush_tid,
  output logic [$clog2(N_ENTRIES):0]   n_valid,
  output logic [CNT_W-1:0]             miss_count
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int NV_W  = IDX_W + 1;

  logic [N_ENTRIES-1:0] valid, valid_nx;
  logic [TID_W-1:0]     tid_q [N_ENTRIES];
  logic [VPN_W-1:0]     vpn_q [N_ENTRIES];
  logic [PPN_W-1:0]     ppn_q [N_ENTRIES];
  logic [IDX_W-1:0]     victim;

  logic [VPN_W-1:0] req_vpn;
  logic             lk_hit;
  logic [PPN_W-1:0] lk_ppn;

  logic             wr_hit, free_any, do_wr;
  logic [IDX_W-1:0] wr_hit_idx, free_idx, wr_idx;
  logic [NV_W-1:0]  cnt_nx;

  assign req_vpn = req_vaddr[VPN_W+OFF_W-1:OFF_W];

  // Matches are unique per (tid, vpn), so OR-combining the matched ppn is safe.
  always_comb begin
    lk_hit = 1'b0;
    lk_ppn = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (valid[i] && tid_q[i] == req_tid && vpn_q[i] == req_vpn) begin
        lk_hit = 1'b1;
        lk_ppn = lk_ppn | ppn_q[i];
      end
    end
  end

  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_any   = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (valid[i] && tid_q[i] == wr_tid && vpn_q[i] == wr_vpn) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!valid[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    wr_idx = wr_hit ? wr_hit_idx : (free_any ? free_idx : victim);
    do_wr  = wr_en && !flush_all && !flush_tid_en;
  end

  always_comb begin
    valid_nx = valid;
    cnt_nx   = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (flush_all)
        valid_nx[i] = 1'b0;
      else if (flush_tid_en && tid_q[i] == flush_tid)
        valid_nx[i] = 1'b0;
      else if (do_wr && IDX_W'(i) == wr_idx)
        valid_nx[i] = 1'b1;
      cnt_nx = cnt_nx + NV_W'(valid_nx[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      tid_q[wr_idx] <= wr_tid;
      vpn_q[wr_idx] <= wr_vpn;
      ppn_q[wr_idx] <= wr_ppn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      victim     <= '0;
      n_valid    <= '0;
      miss_count <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_miss   <= 1'b0;
      rsp_paddr  <= '0;
      rsp_tid    <= '0;
    end else begin
      valid   <= valid_nx;
      n_valid <= cnt_nx;
      if (do_wr && !wr_hit && !free_any)
        victim <= (victim == IDX_W'(N_ENTRIES - 1)) ? '0 : victim + 1'b1;
      rsp_valid <= req_valid;
      rsp_hit   <= req_valid && lk_hit;
      rsp_miss  <= req_valid && !lk_hit;
      rsp_paddr <= (req_valid && lk_hit) ? {lk_ppn, req_vaddr[OFF_W-1:0]} : '0;
      rsp_tid   <= req_valid ? req_tid : '0;
      if (req_valid && !lk_hit && miss_count != '1)
        miss_count <= miss_count + 1'b1;
    end
  end
endmodule
